// File: rtl/car_link_responder.sv
// car_link_responder
//   Simulator-side endpoint of the car command link. Receives 8N1 UART
//   command frames {2'b10, destroy_barrier, place_barrier, turn_right,
//   turn_left, move_backward, move_forward}. It checks each frame and
//   decodes it into held command outputs. Every accepted frame is answered
//   with one 8N1 status byte {4'b0000, back, right, left, front}.
//
// Parameters
//   CLKS_PER_BIT : sys_clk cycles per UART bit (even, >= 8)
//   WDT_CYCLES   : command watchdog timeout in cycles
//
// Optional feature
//   CMD_WATCHDOG_EN : when defined, the six commands clear to 0 and
//                     wdt_timeout pulses once after WDT_CYCLES cycles
//                     without an accepted frame. When undefined, commands
//                     hold indefinitely and wdt_timeout is tied to 0.
//
// Ports
//   sys_clk            : system clock, rising edge
//   rst                : asynchronous active-high reset
//   rxd / txd          : serial command input / serial status output (idle high)
//   *_detector         : detector levels reported in the status byte
//   move_*, turn_*,
//   place_/destroy_barrier : decoded held commands
//   frame_valid        : 1-cycle pulse when a frame is accepted
//   frame_error        : 1-cycle pulse on a bad stop bit or a bad header
//   wdt_timeout        : 1-cycle pulse when the watchdog clears the commands
module car_link_responder #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WDT_CYCLES   = 10_000_000
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic rxd,
  output logic txd,
  input  logic front_detector,
  input  logic left_detector,
  input  logic right_detector,
  input  logic back_detector,
  output logic move_forward,
  output logic move_backward,
  output logic turn_left,
  output logic turn_right,
  output logic place_barrier,
  output logic destroy_barrier,
  output logic frame_valid,
  output logic frame_error,
  output logic wdt_timeout
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  // rxd synchronizer; resets to the idle level so no false start is seen
  logic r_rx_meta;
  logic r_rx_sync;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rxd;
      r_rx_sync <= r_rx_meta;
    end
  end

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  rx_state_t     r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic [5:0]    r_cmd;
  logic          r_frame_valid;
  logic          r_frame_error;
  logic          r_wdt_timeout;

  logic          w_stop_tick;
  logic          w_accept;
  logic [5:0]    w_cmd_next;
  logic          w_wdt_expire;

  assign w_stop_tick = (r_rx_state == RX_STOP) && (r_rx_cnt == FULL_M1);
  assign w_accept    = w_stop_tick && r_rx_sync && (r_rx_shift[7:6] == 2'b10);
  // Contradictory forward+backward request resolves to "no motion"
  assign w_cmd_next  = {r_rx_shift[5:2],
                        (r_rx_shift[1:0] == 2'b11) ? 2'b00 : r_rx_shift[1:0]};

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_rx_state    <= RX_IDLE;
      r_rx_cnt      <= '0;
      r_rx_bit      <= '0;
      r_rx_shift    <= '0;
      r_cmd         <= '0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_wdt_timeout <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_wdt_timeout <= 1'b0;

      if (w_wdt_expire) begin
        r_cmd         <= '0;
        r_wdt_timeout <= 1'b1;
      end

      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_sync) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end

        // Mid-start-bit check rejects short low glitches without an error
        RX_START: begin
          if (r_rx_cnt == HALF_M1) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end

        RX_DATA: begin
          if (r_rx_cnt == FULL_M1) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
            if (r_rx_bit == 3'd7) begin
              r_rx_state <= RX_STOP;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end

        RX_STOP: begin
          if (w_stop_tick) begin
            r_rx_cnt <= '0;
            if (!r_rx_sync) begin
              // Framing error: wait for the line to recover before re-arming
              r_frame_error <= 1'b1;
              r_rx_state    <= RX_WAIT_HIGH;
            end else if (!w_accept) begin
              r_frame_error <= 1'b1;
              r_rx_state    <= RX_IDLE;
            end else begin
              // Placed after the watchdog clear so a new frame wins a tie
              r_frame_valid <= 1'b1;
              r_cmd         <= w_cmd_next;
              r_rx_state    <= RX_IDLE;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end

        RX_WAIT_HIGH: begin
          if (r_rx_sync) begin
            r_rx_state <= RX_IDLE;
          end
        end

        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

`ifdef CMD_WATCHDOG_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);

  logic [WW-1:0] r_wdt_cnt;
  logic          r_wdt_done;
  logic          w_wdt_hit;

  assign w_wdt_hit    = !r_wdt_done && (r_wdt_cnt == WW'(WDT_CYCLES - 1));
  assign w_wdt_expire = w_wdt_hit && !w_accept;

  // Counter restarts on every accepted frame and freezes once it has fired
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_wdt_cnt  <= '0;
      r_wdt_done <= 1'b0;
    end else if (w_accept) begin
      r_wdt_cnt  <= '0;
      r_wdt_done <= 1'b0;
    end else if (!r_wdt_done) begin
      r_wdt_cnt <= r_wdt_cnt + 1'b1;
      if (w_wdt_hit) begin
        r_wdt_done <= 1'b1;
      end
    end
  end
`else
  // Never true; keeps the timeout parameter referenced in this build
  assign w_wdt_expire = (WDT_CYCLES < 0);
`endif

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  tx_state_t     r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          r_txd;
  logic          r_pending;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
      r_pending  <= 1'b0;
    end else begin
      // One-deep request memory; repeated requests collapse into it
      if (r_frame_valid && (r_tx_state != TX_IDLE)) begin
        r_pending <= 1'b1;
      end

      case (r_tx_state)
        TX_IDLE: begin
          if (r_frame_valid || r_pending) begin
            r_tx_shift <= {4'b0000, back_detector, right_detector,
                           left_detector, front_detector};
            r_txd      <= 1'b0;
            r_tx_cnt   <= '0;
            r_pending  <= 1'b0;
            r_tx_state <= TX_START;
          end
        end

        TX_START: begin
          if (r_tx_cnt == FULL_M1) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end

        TX_DATA: begin
          if (r_tx_cnt == FULL_M1) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_txd      <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx_bit   <= r_tx_bit + 1'b1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end

        // Returning through IDLE guarantees at least one idle-high cycle
        TX_STOP: begin
          if (r_tx_cnt == FULL_M1) begin
            r_tx_cnt   <= '0;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end

        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign txd             = r_txd;
  assign move_forward    = r_cmd[0];
  assign move_backward   = r_cmd[1];
  assign turn_left       = r_cmd[2];
  assign turn_right      = r_cmd[3];
  assign place_barrier   = r_cmd[4];
  assign destroy_barrier = r_cmd[5];
  assign frame_valid     = r_frame_valid;
  assign frame_error     = r_frame_error;
  assign wdt_timeout     = r_wdt_timeout;

endmodule

// File: tb/tb_car_link_responder.sv
module tb_car_link_responder;

  localparam int CPB = 16;
  localparam int WDT = 1000;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  logic rxd     = 1'b1;
  logic txd;
  logic front_detector = 1'b0;
  logic left_detector  = 1'b0;
  logic right_detector = 1'b0;
  logic back_detector  = 1'b0;
  logic move_forward, move_backward, turn_left, turn_right;
  logic place_barrier, destroy_barrier;
  logic frame_valid, frame_error, wdt_timeout;

  car_link_responder #(
    .CLKS_PER_BIT(CPB),
    .WDT_CYCLES  (WDT)
  ) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .rxd            (rxd),
    .txd            (txd),
    .front_detector (front_detector),
    .left_detector  (left_detector),
    .right_detector (right_detector),
    .back_detector  (back_detector),
    .move_forward   (move_forward),
    .move_backward  (move_backward),
    .turn_left      (turn_left),
    .turn_right     (turn_right),
    .place_barrier  (place_barrier),
    .destroy_barrier(destroy_barrier),
    .frame_valid    (frame_valid),
    .frame_error    (frame_error),
    .wdt_timeout    (wdt_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit edge_live = 1'b0;

  always @(posedge sys_clk) begin
    cyc++;
    edge_live = !rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model state ----------------
  typedef struct {
    bit         valid;
    logic [5:0] cmd;
    int         c0;
  } rx_ev_t;

  rx_ev_t     rxq[$];
  logic [7:0] repq[$];
  logic [5:0] exp_cmd = '0;
  int         wdt_cnt = 0;
  bit         wdt_fired = 1'b0;
  bit         tx_busy = 1'b0;
  int         tx_rel = 0;
  logic [7:0] tx_exp = '0;
  logic [7:0] tx_got = '0;
  logic [7:0] last_reply = '0;
  bit         tx_known = 1'b0;
  int         start_by = -1;
  int         n_valid = 0, n_err = 0, n_reply = 0, n_wdt = 0;
  rx_ev_t     ev;
  logic [9:0] tx_frame;
  bit         got_valid;
  bit         exp_wdt;
  int         dly;

  function automatic logic [5:0] cmd_of(input logic [7:0] b);
    logic [5:0] c;
    c = b[5:0];
    if (b[1:0] == 2'b11) c[1:0] = 2'b00;
    return c;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge sys_clk) begin
    if (rst) begin
      rxq.delete();
      repq.delete();
      exp_cmd   = '0;
      wdt_cnt   = 0;
      wdt_fired = 1'b0;
      tx_busy   = 1'b0;
      start_by  = -1;
    end else if (edge_live) begin
      got_valid = 1'b0;
      exp_wdt   = 1'b0;
      check("fv_fe_exclusive", 32'(frame_valid & frame_error), 32'd0);
      if (frame_valid) n_valid++;
      if (frame_error) n_err++;
      if (wdt_timeout) n_wdt++;

      if (frame_valid | frame_error) begin
        if (rxq.size() == 0) begin
          check("unexpected_rx_pulse", 32'({frame_valid, frame_error}), 32'd0);
        end else begin
          ev  = rxq.pop_front();
          dly = cyc - ev.c0;
          check("rx_pulse_kind", 32'({frame_valid, frame_error}), ev.valid ? 32'd2 : 32'd1);
          check("rx_pulse_timing", 32'(dly >= 153 && dly <= 157), 32'd1);
          if (ev.valid && frame_valid) begin
            got_valid = 1'b1;
            exp_cmd   = ev.cmd;
            wdt_cnt   = 0;
            wdt_fired = 1'b0;
            repq.push_back({4'b0000, back_detector, right_detector, left_detector, front_detector});
            if (!tx_busy && repq.size() == 1) start_by = cyc + 2;
          end
        end
      end

`ifdef CMD_WATCHDOG_EN
      if (!got_valid && !wdt_fired) begin
        wdt_cnt++;
        if (wdt_cnt == WDT) begin
          exp_cmd   = '0;
          wdt_fired = 1'b1;
          exp_wdt   = 1'b1;
        end
      end
`endif
      check("wdt_timeout", 32'(wdt_timeout), 32'(exp_wdt));
      check("commands", 32'({destroy_barrier, place_barrier, turn_right, turn_left,
                              move_backward, move_forward}), 32'(exp_cmd));

      // reply waveform monitor
      if (!tx_busy) begin
        if (txd === 1'b0) begin
          tx_busy  = 1'b1;
          tx_rel   = 0;
          start_by = -1;
          tx_known = (repq.size() != 0);
          check("reply_expected", 32'(tx_known), 32'd1);
          tx_exp   = tx_known ? repq.pop_front() : 8'h00;
        end else begin
          check("txd_idle", 32'(txd), 32'd1);
          if (start_by >= 0 && cyc > start_by) begin
            check("reply_start_latency", 32'(cyc - start_by + 2), 32'd2);
            start_by = -1;
          end
        end
      end else begin
        tx_rel++;
        tx_frame = {1'b1, tx_exp, 1'b0};
        if (tx_rel < 10 * CPB) begin
          if (tx_known) check("txd_bit", 32'(txd), 32'(tx_frame[tx_rel / CPB]));
          if ((tx_rel % CPB) == CPB / 2 && tx_rel > CPB && tx_rel < 9 * CPB)
            tx_got[tx_rel / CPB - 1] = txd;
        end else begin
          check("txd_gap_after_stop", 32'(txd), 32'd1);
          tx_busy    = 1'b0;
          last_reply = tx_got;
          n_reply++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx_ev_t e;
    @(posedge sys_clk);
    #1;
    e.valid = stop_ok && (b[7:6] == 2'b10);
    e.cmd   = cmd_of(b);
    e.c0    = cyc;
    rxq.push_back(e);
    rxd = 1'b0;
    repeat (CPB) @(posedge sys_clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(posedge sys_clk);
      #1;
    end
    rxd = stop_ok;
    repeat (CPB) @(posedge sys_clk);
    #1;
    rxd = 1'b1;
    if (!stop_ok) begin
      repeat (4) @(posedge sys_clk);
      #1;
    end
    check("rx_response_seen", 32'(rxq.size()), 32'd0);
    rxq.delete();
  endtask

  task automatic send_glitch();
    @(posedge sys_clk);
    #1;
    rxd = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    rxd = 1'b1;
    repeat (2 * CPB) @(posedge sys_clk);
  endtask

  task automatic wait_replies();
    int t = 0;
    while ((repq.size() != 0 || tx_busy) && t < 1000) begin
      @(posedge sys_clk);
      t++;
    end
    check("reply_drain", 32'(repq.size() != 0 || tx_busy), 32'd0);
    repeat (4) @(posedge sys_clk);
  endtask

  task automatic set_dets(input logic [3:0] d);
    {back_detector, right_detector, left_detector, front_detector} = d;
  endtask

  function automatic logic [5:0] outs();
    return {destroy_barrier, place_barrier, turn_right, turn_left, move_backward, move_forward};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int v0, e0, r0, w0;
    logic [7:0] b;
    int nb;

    repeat (3) @(posedge sys_clk);
    #3 rst = 1'b0;
    @(posedge sys_clk);
    #1;
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_cmds", 32'(outs()), 32'd0);
    check("reset_pulses", 32'({frame_valid, frame_error, wdt_timeout}), 32'd0);

    // 0x85 with front=1, back=1 -> move_forward + turn_left, reply 0x09
    set_dets(4'b1001);
    v0 = n_valid; r0 = n_reply;
    send_byte(8'h85, 1'b1);
    wait_replies();
    check("t1_cmds", 32'(outs()), 32'h05);
    check("t1_valid_count", 32'(n_valid - v0), 32'd1);
    check("t1_reply_count", 32'(n_reply - r0), 32'd1);
    check("t1_reply_byte", 32'(last_reply), 32'h09);

    // bad header, then bad stop bit
    e0 = n_err; r0 = n_reply;
    send_byte(8'h45, 1'b1);
    send_byte(8'h85, 1'b0);
    repeat (40) @(posedge sys_clk);
    check("t2_error_count", 32'(n_err - e0), 32'd2);
    check("t2_cmds_held", 32'(outs()), 32'h05);
    check("t2_no_reply", 32'(n_reply - r0), 32'd0);

    // forward+backward both requested
    r0 = n_reply;
    set_dets(4'b0110);
    send_byte(8'h83, 1'b1);
    check("t3_cmds", 32'(outs()), 32'h00);
    wait_replies();
    check("t3_reply_count", 32'(n_reply - r0), 32'd1);
    check("t3_reply_byte", 32'(last_reply), 32'h06);

    // three back-to-back frames
    r0 = n_reply;
    set_dets(4'b1111);
    send_byte(8'h81, 1'b1);
    send_byte(8'hA4, 1'b1);
    send_byte(8'h92, 1'b1);
    wait_replies();
    check("t4_reply_count", 32'(n_reply - r0), 32'd3);
    check("t4_reply_byte", 32'(last_reply), 32'h0F);
    check("t4_cmds", 32'(outs()), 32'h12);

    // watchdog
    w0 = n_wdt;
    send_byte(8'h81, 1'b1);
    wait_replies();
    repeat (WDT + 100) @(posedge sys_clk);
    #1;
`ifdef CMD_WATCHDOG_EN
    check("t5_move_forward", 32'(move_forward), 32'd0);
    check("t5_wdt_pulses", 32'(n_wdt - w0), 32'd1);
`else
    check("t5_move_forward", 32'(move_forward), 32'd1);
    check("t5_wdt_pulses", 32'(n_wdt - w0), 32'd0);
`endif

    // reset in the middle of a reply's data bits
    set_dets(4'b1001);
    send_byte(8'h85, 1'b1);
    repeat (40) @(posedge sys_clk);
    #3 rst = 1'b1;
    #1;
    check("t6_txd_reset", 32'(txd), 32'd1);
    check("t6_cmds_reset", 32'(outs()), 32'd0);
    check("t6_pulses_reset", 32'({frame_valid, frame_error, wdt_timeout}), 32'd0);
    @(posedge sys_clk);
    #3 rst = 1'b0;
    repeat (3) @(posedge sys_clk);
    r0 = n_reply;
    send_byte(8'h85, 1'b1);
    wait_replies();
    check("t6_cmds_after", 32'(outs()), 32'h05);
    check("t6_reply_count", 32'(n_reply - r0), 32'd1);
    check("t6_reply_byte", 32'(last_reply), 32'h09);

    // randomized bursts
    for (int it = 0; it < 30; it++) begin
      set_dets(4'($urandom));
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 3) != 0) b = {2'b10, 6'($urandom)};
        else b = 8'($urandom);
        send_byte(b, $urandom_range(0, 6) != 0);
      end
      if ($urandom_range(0, 3) == 0) send_glitch();
      wait_replies();
      repeat ($urandom_range(0, 40)) @(posedge sys_clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/car_link_responder.md
# car_link_responder

Simulator-side endpoint of the car command link. It receives the 8-bit UART command frames the car controller transmits ({2'b10, destroy_barrier, place_barrier, turn_right, turn_left, move_backward, move_forward}), validates and decodes them into held command outputs, and answers every valid frame with one UART status byte carrying the four detector bits. It sits opposite the controller's UART, clocked from the same 100 MHz sys_clk.

## Interface
- CLKS_PER_BIT, 868, sys_clk cycles per UART bit (115200 baud at 100 MHz); must be even and ≥ 8.
- WDT_CYCLES, 10_000_000, command watchdog timeout in cycles (only used with CMD_WATCHDOG_EN).
- sys_clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rxd  in  1  serial command stream from the controller; idle high.
- txd  out  1  serial status stream to the controller; idle high.
- front_detector, left_detector, right_detector, back_detector  in  1 each  detector levels to report.
- move_forward, move_backward, turn_left, turn_right, place_barrier, destroy_barrier  out  1 each  decoded held commands.
- frame_valid  out  1  one-cycle pulse on acceptance of a valid frame.
- frame_error  out  1  one-cycle pulse on a rejected frame.
- wdt_timeout  out  1  one-cycle pulse when the watchdog clears commands; constant 0 without CMD_WATCHDOG_EN.

## Operation
- rxd passes through a 2-FF synchronizer (reset value 1); all RX decisions use the synchronized value.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE, plus WAIT_HIGH.
  - IDLE: synchronized low starts the bit counter and enters START.
  - START: at CLKS_PER_BIT/2 re-sample; high -> glitch, return to IDLE silently; low -> DATA.
  - DATA: 8 samples, each CLKS_PER_BIT after the previous, LSB first.
  - STOP: sample once. If 0: frame_error, byte discarded, enter WAIT_HIGH until line is high, then IDLE.
- Header check on a byte with a good stop bit: bits[7:6] != 2'b10 -> frame_error, outputs unchanged.
- Valid byte: frame_valid pulses; command outputs load bits[5:0] in the same edge. If bits[1:0] == 2'b11, move_forward and move_backward are both forced 0 and the other four bits load normally.
- Each valid frame requests a reply. TX FSM: IDLE -> START -> DATA -> STOP -> IDLE, 8N1, LSB first.
- Reply byte = {4'b0000, back_detector, right_detector, left_detector, front_detector}, captured on the cycle TX leaves IDLE.
- One-deep pending flag: a request while TX is busy sets pending. Further requests while pending is already set are merged. TX restarts from IDLE on the cycle after STOP if pending is set, then clears it.
- Reset: all command outputs, frame_valid, frame_error, wdt_timeout and pending = 0; txd = 1; both FSMs in IDLE. Reset mid-frame aborts RX and TX immediately; txd goes high asynchronously.

## Timing
- Stop-bit sample at 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles (±1) after the rxd falling edge.
- Command outputs, frame_valid and frame_error update on the edge of the stop-bit sample.
- txd start bit begins ≤ 2 cycles after frame_valid when TX is idle.
- Every TX bit lasts exactly CLKS_PER_BIT cycles; one reply = 10·CLKS_PER_BIT cycles.
- After STOP, txd stays high for at least 1 cycle before the next start bit.
- frame_valid and frame_error are never high in the same cycle.

## Configuration
- CMD_WATCHDOG_EN defined:
  - A counter clears on every frame_valid and counts otherwise.
  - When it reaches WDT_CYCLES, all six command outputs clear to 0 and wdt_timeout pulses once.
  - The counter then holds until the next valid frame.
- CMD_WATCHDOG_EN undefined: no counter is built, commands hold indefinitely, and wdt_timeout is tied to 0.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- Send 0x85 with front=1, back=1, left=0, right=0 -> move_forward=1, turn_left=1, others 0; one frame_valid pulse; txd sends 0x09.
- Send 0x45 (bad header), then 0x85 with stop bit 0 -> two frame_error pulses; outputs unchanged; txd stays high.
- Send 0x83 -> move_forward=0, move_backward=0, frame_valid=1; reply still sent.
- Send three back-to-back valid frames -> exactly three replies, each 160 cycles, with no txd glitch.
- With CMD_WATCHDOG_EN and WDT_CYCLES=1000: send 0x81, then idle -> move_forward falls 1000 cycles after frame_valid, with a wdt_timeout pulse. Without the macro, move_forward stays 1.
- Assert rst during a reply's DATA phase -> txd=1 and all outputs 0 immediately; the next valid frame is decoded and answered normally.
